sparse_encoder: RTL

SPARSE_ENCODER -- requirements
Module: sparse_encoder

---
 rtl/sparse_mac_pkg.sv | 25 ++
 rtl/sparse_encoder_wr_stage.sv | 63 ++++++
 rtl/sparse_encoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sparse_mac_pkg.sv
// Shared types for the sparse MAC datapath: value/index buses, the encoded SRAM
// entry layout, and the encoder state enum.
package sparse_mac_pkg;

   localparam int VALUE_W = 16;
   localparam int INDEX_W = 16;

   typedef logic [VALUE_W-1:0] value_bus_t;
   typedef logic [INDEX_W-1:0] index_bus_t;

   typedef struct packed {
      logic       done;
      value_bus_t value;
      index_bus_t skip;
   } sram_data_t;

   typedef enum logic [1:0] {
      ENC_IDLE,
      ENC_RUN,
      ENC_FLUSH
   } enc_state_e;

   localparam index_bus_t SKIP_MAX = '1;

endpackage

// File: rtl/sparse_encoder_wr_stage.sv
// Single-entry SRAM write holding register plus the write address counter.
// The address advances only when a write actually completes.
module sparse_encoder_wr_stage
   import sparse_mac_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              addr_load_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic              push_i,
   input  sram_data_t        push_data_i,
   input  logic              sram_wr_ready_i,
   output logic              can_push_o,
   output logic              wr_done_o,
   output logic              pending_o,
   output logic              sram_wr_en_o,
   output logic [ADDR_W-1:0] sram_wr_addr_o,
   output sram_data_t        sram_wr_data_o
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   sram_data_t        data_q, data_d;

   always_comb begin
      valid_d   = valid_q;
      addr_d    = addr_q;
      data_d    = data_q;
      wr_done_o = valid_q && sram_wr_ready_i;
      if (wr_done_o) begin
         valid_d = 1'b0;
         addr_d  = addr_q + ADDR_W'(1);
      end
      if (push_i) begin
         valid_d = 1'b1;
         data_d  = push_data_i;
      end
      if (addr_load_i) begin
         addr_d = base_addr_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign can_push_o     = !valid_q || sram_wr_ready_i;
   assign pending_o      = valid_q;
   assign sram_wr_en_o   = valid_q;
   assign sram_wr_addr_o = addr_q;
   assign sram_wr_data_o = data_q;

endmodule

// File: rtl/sparse_encoder.sv
// Dense-to-sparse run-length encoder: zeros are elided and counted into the
// skip field of the next emitted entry, entries are written to SRAM in order.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ENC_IDLE  | waiting for start; entry_count/overflow hold last results
// ENC_RUN   | consuming dense elements, emitting entries into wr stage
// ENC_FLUSH | last element taken; waiting for final write to complete
module sparse_encoder
   import sparse_mac_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   max_entries,
   input  logic              in_valid,
   output logic              in_ready,
   input  value_bus_t        in_value,
   input  logic              in_last,
   output logic              sram_wr_en,
   input  logic              sram_wr_ready,
   output logic [ADDR_W-1:0] sram_wr_addr,
   output sram_data_t        sram_wr_data,
   output logic              busy,
   output logic              vec_done,
   output logic [ADDR_W:0]   entry_count,
   output logic              overflow
);

   enc_state_e      state_q, state_d;
   index_bus_t      z_q, z_d;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic [ADDR_W:0] max_q, max_d;
   logic            ovf_q, ovf_d;

   logic       can_push, wr_done, pending;
   logic       push, addr_load, accept, emit;
   sram_data_t push_data;

   assign in_ready  = (state_q == ENC_RUN) && can_push;
   assign accept    = in_valid && in_ready;
   assign emit      = (in_value != '0) || in_last || (z_q == SKIP_MAX);
   assign push_data = '{done: in_last, value: in_value, skip: z_q};

   always_comb begin
      state_d   = state_q;
      z_d       = z_q;
      cnt_d     = cnt_q;
      max_d     = max_q;
      ovf_d     = ovf_q;
      push      = 1'b0;
      addr_load = 1'b0;
      vec_done  = 1'b0;
      case (state_q)
         ENC_IDLE: begin
            if (start) begin
               state_d   = ENC_RUN;
               max_d     = max_entries;
               z_d       = '0;
               cnt_d     = '0;
               ovf_d     = 1'b0;
               addr_load = 1'b1;
            end
         end
         ENC_RUN: begin
            if (accept) begin
               if (emit) begin
                  z_d = '0;
                  // Budget exhausted: entry is dropped but input keeps flowing.
                  if (cnt_q == max_q) begin
                     ovf_d = 1'b1;
                  end else begin
                     push  = 1'b1;
                     cnt_d = cnt_q + (ADDR_W+1)'(1);
                  end
               end else begin
                  z_d = z_q + index_bus_t'(1);
               end
               if (in_last) begin
                  state_d = ENC_FLUSH;
               end
            end
         end
         ENC_FLUSH: begin
            if (!pending || wr_done) begin
               vec_done = 1'b1;
               state_d  = ENC_IDLE;
            end
         end
         default: state_d = ENC_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ENC_IDLE;
         z_q     <= '0;
         cnt_q   <= '0;
         max_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
         max_q   <= max_d;
         ovf_q   <= ovf_d;
      end
   end

   sparse_encoder_wr_stage #(
      .ADDR_W(ADDR_W)
   ) u_wr_stage (
      .clk             (clk),
      .rst             (rst),
      .addr_load_i     (addr_load),
      .base_addr_i     (base_addr),
      .push_i          (push),
      .push_data_i     (push_data),
      .sram_wr_ready_i (sram_wr_ready),
      .can_push_o      (can_push),
      .wr_done_o       (wr_done),
      .pending_o       (pending),
      .sram_wr_en_o    (sram_wr_en),
      .sram_wr_addr_o  (sram_wr_addr),
      .sram_wr_data_o  (sram_wr_data)
   );

   assign busy        = (state_q != ENC_IDLE);
   assign entry_count = cnt_q;
   assign overflow    = ovf_q;

endmodule
